// File: rtl/ice_msk_ctl_if.sv
// ice_msk_ctl_if: host register bus for the ICE mask controller.
// Host drives address, write data and strobe; block returns read data.
interface ice_msk_ctl_if;
    logic [31:0] ICEIFA;
    logic [31:0] ICEDI;
    logic        ICEWR;
    logic [31:0] ICEDO;

    modport master (
        output ICEIFA,
        output ICEDI,
        output ICEWR,
        input  ICEDO
    );

    modport slave (
        input  ICEIFA,
        input  ICEDI,
        input  ICEWR,
        output ICEDO
    );
endinterface

// File: rtl/ice_msk_ctl.sv
// ice_msk_ctl: ICE event mask register block with hold timer.
// Optional PEND register and event capture enabled by ICE_MSK_PEND_EN.
module ice_msk_ctl #(
    parameter int              NCH       = 10,
    parameter logic [31:0]     BASE_ADDR = 32'h0880_4000,
    parameter logic [NCH-1:0]  RST_VAL   = 10'h3DD,
    parameter logic [NCH-1:0]  USR_FORCE = 10'h01D
) (
    input  logic               CLK,
    input  logic               SYSRSOUT,
    ice_msk_ctl_if.slave       bus,
    input  logic               SVMODUSER,
    input  logic [NCH-1:0]     ICEEVT,
    output logic [NCH-1:0]     ICEMSK,
    output logic [NCH-1:0]     ICEMSKRAW,
    output logic               ICEMSKTMRACT
);

    typedef enum logic [2:0] {
        R_MASK  = 3'd0,
        R_SET   = 3'd1,
        R_CLR   = 3'd2,
        R_PEND  = 3'd3,
        R_TMR   = 3'd4,
        R_TMRCH = 3'd5,
        R_RSV6  = 3'd6,
        R_RSV7  = 3'd7
    } reg_e;

    logic            sel;
    reg_e            off;
    logic [NCH-1:0]  di;
    logic            wr_mask;
    logic            wr_set;
    logic            wr_clr;
    logic            wr_pend;
    logic            wr_tmr;
    logic            wr_tmrch;

    logic [NCH-1:0]  mask_q;
    logic [NCH-1:0]  mask_nxt;
    logic [NCH-1:0]  tmrch_q;
    logic [15:0]     cnt_q;
    logic [15:0]     cnt_nxt;
    logic [NCH-1:0]  pend_rd;
    logic [31:0]     rdata;

    logic            unused_bus;

    assign sel = (bus.ICEIFA[31:5] == BASE_ADDR[31:5]);
    assign off = reg_e'(bus.ICEIFA[4:2]);
    assign di  = bus.ICEDI[NCH-1:0];

    // Byte-lane bits of the address and upper data bits carry no meaning.
    assign unused_bus = ^{bus.ICEIFA[1:0], bus.ICEDI};

    // Decode a selected write strobe into one per-register enable.
    always_comb begin
        wr_mask  = 1'b0;
        wr_set   = 1'b0;
        wr_clr   = 1'b0;
        wr_pend  = 1'b0;
        wr_tmr   = 1'b0;
        wr_tmrch = 1'b0;
        if (bus.ICEWR && sel) begin
            unique case (off)
                R_MASK:  wr_mask  = 1'b1;
                R_SET:   wr_set   = 1'b1;
                R_CLR:   wr_clr   = 1'b1;
                R_PEND:  wr_pend  = 1'b1;
                R_TMR:   wr_tmr   = 1'b1;
                R_TMRCH: wr_tmrch = 1'b1;
                default: ;
            endcase
        end
    end

    // MASK next value: direct write, set-ones or clear-ones alias.
    always_comb begin
        mask_nxt = mask_q;
        if (wr_mask) begin
            mask_nxt = di;
        end else if (wr_set) begin
            mask_nxt = mask_q | di;
        end else if (wr_clr) begin
            mask_nxt = mask_q & ~di;
        end
    end

    // Hold timer next count: load on write, else count down to zero.
    always_comb begin
        cnt_nxt = cnt_q;
        if (wr_tmr) begin
            cnt_nxt = bus.ICEDI[15:0];
        end else if (cnt_q != 16'd0) begin
            cnt_nxt = cnt_q - 16'd1;
        end
    end

    // Register state; reset wins over any write on the same edge.
    always_ff @(posedge CLK) begin
        if (SYSRSOUT) begin
            mask_q  <= RST_VAL;
            tmrch_q <= '0;
            cnt_q   <= '0;
        end else begin
            mask_q <= mask_nxt;
            cnt_q  <= cnt_nxt;
            if (wr_tmrch) begin
                tmrch_q <= di;
            end
        end
    end

    assign ICEMSKTMRACT = (cnt_q != 16'd0);
    assign ICEMSKRAW    = mask_q;
    assign ICEMSK       = mask_q
                        | (USR_FORCE & {NCH{SVMODUSER}})
                        | (tmrch_q & {NCH{ICEMSKTMRACT}});

`ifdef ICE_MSK_PEND_EN
    logic [NCH-1:0] pend_q;
    logic [NCH-1:0] pend_clr;
    logic [NCH-1:0] pend_set;

    assign pend_clr = wr_pend ? di : '0;
    assign pend_set = ICEEVT & ICEMSK;

    // Sticky pending capture of masked events; set beats clear.
    always_ff @(posedge CLK) begin
        if (SYSRSOUT) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~pend_clr) | pend_set;
        end
    end

    assign pend_rd = pend_q;
`else
    logic unused_pend;

    assign unused_pend = ^{ICEEVT, wr_pend};
    assign pend_rd     = '0;
`endif

    // Read mux, zero-extended; reserved offsets read as zero.
    always_comb begin
        rdata = '0;
        unique case (off)
            R_MASK,
            R_SET,
            R_CLR:   rdata[NCH-1:0] = mask_q;
            R_PEND:  rdata[NCH-1:0] = pend_rd;
            R_TMR:   rdata[15:0]    = cnt_q;
            R_TMRCH: rdata[NCH-1:0] = tmrch_q;
            default: rdata = '0;
        endcase
    end

    assign bus.ICEDO = sel ? rdata : 32'h0;

endmodule

// File: tb/tb_ice_msk_ctl.sv
// tb_ice_msk_ctl: scoreboard bench for ice_msk_ctl.
// Stimulus queues expectations; a negedge monitor pops and compares.
module tb_ice_msk_ctl;

    localparam logic [31:0] A    = 32'h0880_4000;
    localparam logic [31:0] A_ST = A + 32'h04;
    localparam logic [31:0] A_CL = A + 32'h08;
    localparam logic [31:0] A_PD = A + 32'h0C;
    localparam logic [31:0] A_TM = A + 32'h10;
    localparam logic [31:0] A_TC = A + 32'h14;

    localparam int K_DO  = 0;
    localparam int K_MSK = 1;
    localparam int K_RAW = 2;
    localparam int K_ACT = 3;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic       CLK = 1'b0;
    logic       SYSRSOUT;
    logic       SVMODUSER;
    logic [9:0] ICEEVT;
    logic [9:0] ICEMSK;
    logic [9:0] ICEMSKRAW;
    logic       ICEMSKTMRACT;

    ice_msk_ctl_if bus ();

    ice_msk_ctl dut (
        .CLK          (CLK),
        .SYSRSOUT     (SYSRSOUT),
        .bus          (bus),
        .SVMODUSER    (SVMODUSER),
        .ICEEVT       (ICEEVT),
        .ICEMSK       (ICEMSK),
        .ICEMSKRAW    (ICEMSKRAW),
        .ICEMSKTMRACT (ICEMSKTMRACT)
    );

    always #5 CLK = ~CLK;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    exp_t e;
    logic [31:0] act;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] sample(int kind);
        case (kind)
            K_DO:    return bus.ICEDO;
            K_MSK:   return {22'b0, ICEMSK};
            K_RAW:   return {22'b0, ICEMSKRAW};
            default: return {31'b0, ICEMSKTMRACT};
        endcase
    endfunction

    // Monitor: compare every expectation due this cycle.
    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            act = sample(e.kind);
            total++;
            if (e.cyc != cyc) begin
                bad++;
                $display("FAIL %s: stale check cyc=%0d now=%0d",
                         e.name, e.cyc, cyc);
            end else if (act !== e.exp) begin
                bad++;
                $display("FAIL %s: got %h want %h", e.name, act, e.exp);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.ICEIFA = a;
        bus.ICEDI  = d;
        bus.ICEWR  = 1'b1;
        step();
        bus.ICEWR  = 1'b0;
        bus.ICEDI  = 32'h0;
    endtask

    task automatic chk(input int kind, input logic [31:0] x,
                       input string n);
        sb.push_back('{cyc, kind, x, n});
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] x,
                      input string n);
        bus.ICEIFA = a;
        sb.push_back('{cyc, K_DO, x, n});
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish by time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        SYSRSOUT   = 1'b1;
        SVMODUSER  = 1'b0;
        ICEEVT     = '0;
        bus.ICEIFA = 32'h0;
        bus.ICEDI  = 32'h0;
        bus.ICEWR  = 1'b0;
        step();
        step();
        SYSRSOUT = 1'b0;

        chk(K_RAW, 32'h3DD, "rst_raw");
        chk(K_MSK, 32'h3DD, "rst_msk");
        chk(K_ACT, 32'h0, "rst_act");
        rd(A, 32'h3DD, "rst_rd_mask");
        rd(A_TM, 32'h0, "rst_rd_tmr");
        rd(A_TC, 32'h0, "rst_rd_tmrch");
        rd(A_PD, 32'h0, "rst_rd_pend");

        SYSRSOUT = 1'b1;
        wr(A, 32'h0);
        SYSRSOUT = 1'b0;
        chk(K_RAW, 32'h3DD, "rst_over_wr");

        wr(A, 32'h0);
        chk(K_RAW, 32'h0, "mask_wr0");
        wr(A_ST, 32'h021);
        wr(A_CL, 32'h001);
        chk(K_RAW, 32'h020, "setclr_raw");
        rd(A, 32'h020, "setclr_rd");
        rd(A_ST, 32'h020, "set_alias");
        rd(A_CL, 32'h020, "clr_alias");
        wr(A, 32'hFFFF_FFFF);
        rd(A, 32'h3FF, "mask_trunc");
        rd(A + 32'h3, 32'h3FF, "lowbits_ign");

        wr(A, 32'h0);
        SVMODUSER = 1'b1;
        chk(K_MSK, 32'h01D, "usr_msk");
        chk(K_RAW, 32'h0, "usr_raw");
        step();
        SVMODUSER = 1'b0;
        chk(K_MSK, 32'h0, "usr_off");
        step();

        wr(A_TC, 32'h040);
        rd(A_TC, 32'h040, "tmrch_rd");
        wr(A_TM, 32'd3);
        for (int i = 3; i >= 1; i--) begin
            chk(K_MSK, 32'h040, "tmr_msk");
            chk(K_ACT, 32'h1, "tmr_act");
            rd(A_TM, i, "tmr_cnt");
        end
        chk(K_MSK, 32'h0, "tmr_end_msk");
        chk(K_ACT, 32'h0, "tmr_end_act");
        rd(A_TM, 32'h0, "tmr_end_cnt");

        wr(A_TM, 32'd3);
        chk(K_ACT, 32'h1, "rld_a");
        step();
        chk(K_ACT, 32'h1, "rld_b");
        wr(A_TM, 32'd5);
        for (int i = 5; i >= 1; i--) begin
            chk(K_MSK, 32'h040, "rld_msk");
            rd(A_TM, i, "rld_cnt");
        end
        chk(K_ACT, 32'h0, "rld_end");
        step();

        wr(A_TM, 32'd9);
        step();
        chk(K_ACT, 32'h1, "stop_run");
        wr(A_TM, 32'd0);
        chk(K_ACT, 32'h0, "stop_act");
        chk(K_MSK, 32'h0, "stop_msk");
        step();

        wr(A, 32'h0AA);
        wr(A + 32'h18, 32'hFFFF_FFFF);
        rd(A + 32'h18, 32'h0, "rsv18_rd");
        rd(A + 32'h1C, 32'h0, "rsv1c_rd");
        chk(K_RAW, 32'h0AA, "rsv_nochg");
        wr(32'h0880_5000, 32'h0);
        chk(K_RAW, 32'h0AA, "far_nochg");
        rd(32'h0880_5000, 32'h0, "far_rd");
        wr(32'h0880_5010, 32'd50);
        chk(K_ACT, 32'h0, "far_tmr");
        step();

`ifdef ICE_MSK_PEND_EN
        wr(A, 32'h004);
        ICEEVT = 10'h006;
        step();
        ICEEVT = '0;
        rd(A_PD, 32'h004, "pend_set");
        ICEEVT = 10'h004;
        wr(A_PD, 32'h004);
        ICEEVT = '0;
        rd(A_PD, 32'h004, "pend_race");
        wr(A_PD, 32'h004);
        rd(A_PD, 32'h0, "pend_clr");
`else
        wr(A, 32'h3FF);
        ICEEVT = '1;
        step();
        ICEEVT = '0;
        wr(A_PD, 32'hFFFF_FFFF);
        rd(A_PD, 32'h0, "pend_off");
`endif

        wr(A_TM, 32'd100);
        step();
        step();
        chk(K_ACT, 32'h1, "rst_tmr_run");
        SYSRSOUT = 1'b1;
        step();
        SYSRSOUT = 1'b0;
        chk(K_ACT, 32'h0, "rst_tmr_act");
        chk(K_RAW, 32'h3DD, "rst_tmr_raw");
        rd(A_TM, 32'h0, "rst_tmr_cnt");
        rd(A_TC, 32'h0, "rst_tmr_ch");

        step();
        step();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL %s: never checked cyc=%0d", e.name, e.cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
